// File: rtl/leaf_out_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : leaf_out_arbiter
// Description : Round-robin, burst-limited arbiter sharing the single
//               user-to-interface output port of a leaf among NUM_REQ
//               user-side producers. Each forwarded word is tagged with the
//               index of its source requester and held in a one-entry
//               output register so the interface sees a stable valid/data
//               pair.
// Ports       : clk_user            - only clock
//               reset               - synchronous, active-high
//               din_user2arb        - requester words, i at [i*PAYLOAD_BITS +: PAYLOAD_BITS]
//               vld_user2arb        - per-requester valid
//               ack_arb2user        - per-requester accept (one-hot or zero)
//               dout_arb2interface  - registered forwarded word
//               sel_arb2interface   - source index of dout_arb2interface
//               vld_arb2interface   - output word valid
//               ack_interface2arb   - downstream accept
// Revision    : 1.0 - initial release
// ============================================================================
module leaf_out_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int SEL_BITS     = 2,
    parameter int PAYLOAD_BITS = 32,
    parameter int BURST_LEN    = 4
) (
    input  logic                            clk_user,
    input  logic                            reset,
    input  logic [NUM_REQ*PAYLOAD_BITS-1:0] din_user2arb,
    input  logic [NUM_REQ-1:0]              vld_user2arb,
    output logic [NUM_REQ-1:0]              ack_arb2user,
    output logic [PAYLOAD_BITS-1:0]         dout_arb2interface,
    output logic [SEL_BITS-1:0]             sel_arb2interface,
    output logic                            vld_arb2interface,
    input  logic                            ack_interface2arb
);

    localparam int c_burst_bits = $clog2(BURST_LEN + 1);

    localparam logic [0:0] c_st_idle  = 1'b0;
    localparam logic [0:0] c_st_grant = 1'b1;

    localparam logic [SEL_BITS-1:0]     c_last_req   = SEL_BITS'(NUM_REQ - 1);
    localparam logic [c_burst_bits-1:0] c_burst_last = c_burst_bits'(BURST_LEN - 1);
    localparam logic [c_burst_bits-1:0] c_burst_one  = c_burst_bits'(1);

    logic [0:0]              r_state;
    logic [SEL_BITS-1:0]     r_grant;
    logic [SEL_BITS-1:0]     r_ptr;
    logic [c_burst_bits-1:0] r_burst_cnt;
    logic                    r_out_vld;
    logic [PAYLOAD_BITS-1:0] r_dout;
    logic [SEL_BITS-1:0]     r_sel;

    logic [PAYLOAD_BITS-1:0] w_din [NUM_REQ];
    logic [SEL_BITS-1:0]     w_pick_hi;
    logic [SEL_BITS-1:0]     w_pick_lo;
    logic                    w_hit_hi;
    logic [SEL_BITS-1:0]     w_pick;
    logic                    w_slot_free;
    logic                    w_grant_vld;
    logic                    w_accept;
    logic [SEL_BITS-1:0]     w_ptr_next;

    // Split the flat requester bus into one word per requester.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_din[g] = din_user2arb[g*PAYLOAD_BITS +: PAYLOAD_BITS];
    end

    // Round-robin pick: the lowest valid index at or above ptr wins; if none,
    // the search wraps and the lowest valid index overall wins. Scanning from
    // the top down leaves the lowest qualifying index in each candidate.
    always_comb begin
        w_pick_hi = '0;
        w_pick_lo = '0;
        w_hit_hi  = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (vld_user2arb[i]) begin
                w_pick_lo = SEL_BITS'(i);
                if (SEL_BITS'(i) >= r_ptr) begin
                    w_pick_hi = SEL_BITS'(i);
                    w_hit_hi  = 1'b1;
                end
            end
        end
        w_pick = w_hit_hi ? w_pick_hi : w_pick_lo;
    end

    // The output slot can take a word when empty or when it drains this cycle.
    assign w_slot_free = !r_out_vld || ack_interface2arb;
    assign w_grant_vld = vld_user2arb[r_grant];
    assign w_accept    = (r_state == c_st_grant) && w_grant_vld && w_slot_free;
    assign w_ptr_next  = (r_grant == c_last_req) ? '0 : r_grant + 1'b1;

    // Accept is combinational and depends only on control, never on data.
    always_comb begin
        ack_arb2user = '0;
        if (w_accept) begin
            ack_arb2user[r_grant] = 1'b1;
        end
    end

    always_ff @(posedge clk_user) begin
        if (reset) begin
            r_state     <= c_st_idle;
            r_grant     <= '0;
            r_ptr       <= '0;
            r_burst_cnt <= '0;
            r_out_vld   <= 1'b0;
            r_dout      <= '0;
            r_sel       <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (|vld_user2arb) begin
                        r_grant     <= w_pick;
                        r_burst_cnt <= '0;
                        r_state     <= c_st_grant;
                    end
                end
                default: begin
                    if (w_accept) begin
                        r_burst_cnt <= r_burst_cnt + c_burst_one;
                    end
                    // Release on a full burst or as soon as the owner drops
                    // valid; a withdrawn requester forfeits its remaining slots.
                    if (!w_grant_vld || (w_accept && (r_burst_cnt == c_burst_last))) begin
                        r_state <= c_st_idle;
                        r_ptr   <= w_ptr_next;
                    end
                end
            endcase

            // A load may coincide with a drain; the new word then simply
            // replaces the old one and valid stays high.
            if (w_accept) begin
                r_dout    <= w_din[r_grant];
                r_sel     <= r_grant;
                r_out_vld <= 1'b1;
            end else if (r_out_vld && ack_interface2arb) begin
                r_out_vld <= 1'b0;
            end
        end
    end

    assign dout_arb2interface = r_dout;
    assign sel_arb2interface  = r_sel;
    assign vld_arb2interface  = r_out_vld;

endmodule
`default_nettype wire

// File: tb/tb_leaf_out_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_leaf_out_arbiter
// Description : Directed self-checking bench for leaf_out_arbiter. Requesters
//               present incrementing words from a per-test base value; every
//               output transfer is logged with its cycle number and compared
//               against hand-derived expected streams.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_leaf_out_arbiter;

    localparam int NUM_REQ      = 4;
    localparam int SEL_BITS     = 2;
    localparam int PAYLOAD_BITS = 32;
    localparam int BURST_LEN    = 4;

    logic                            clk    = 1'b0;
    logic                            reset  = 1'b1;
    logic [NUM_REQ*PAYLOAD_BITS-1:0] din;
    logic [NUM_REQ-1:0]              vld;
    logic [NUM_REQ-1:0]              ack;
    logic [PAYLOAD_BITS-1:0]         dout;
    logic [SEL_BITS-1:0]             sel;
    logic                            vld_if;
    logic                            ack_if = 1'b1;

    logic [NUM_REQ-1:0] en = '0;
    int                 limit [NUM_REQ];
    logic [31:0]        base  [NUM_REQ];
    int                 idx   [NUM_REQ];
    int                 cyc = 0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mon_dout [$];
    logic [1:0]  mon_sel  [$];
    int          mon_cyc  [$];
    logic [31:0] eq_dout  [$];
    logic [1:0]  eq_sel   [$];
    int          eq_cyc   [$];

    always #5 clk = ~clk;

    leaf_out_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .SEL_BITS     (SEL_BITS),
        .PAYLOAD_BITS (PAYLOAD_BITS),
        .BURST_LEN    (BURST_LEN)
    ) dut (
        .clk_user           (clk),
        .reset              (reset),
        .din_user2arb       (din),
        .vld_user2arb       (vld),
        .ack_arb2user       (ack),
        .dout_arb2interface (dout),
        .sel_arb2interface  (sel),
        .vld_arb2interface  (vld_if),
        .ack_interface2arb  (ack_if)
    );

    // Requester i offers base[i]+idx[i] while enabled and below its word limit.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            din[i*PAYLOAD_BITS +: PAYLOAD_BITS] = base[i] + 32'(idx[i]);
            vld[i] = en[i] && (idx[i] < limit[i]);
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            for (int i = 0; i < NUM_REQ; i++) idx[i] <= 0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (vld[i] && ack[i]) idx[i] <= idx[i] + 1;
            end
            if (vld_if && ack_if) begin
                mon_dout.push_back(dout);
                mon_sel.push_back(sel);
                mon_cyc.push_back(cyc);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        en     = '0;
        ack_if = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            limit[i] = 0;
            base[i]  = 32'h0;
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic add_exp(input logic [1:0] s, input logic [31:0] d, input int c);
        eq_sel.push_back(s);
        eq_dout.push_back(d);
        eq_cyc.push_back(c);
    endtask

    task automatic compare_stream(input string tag, input int n0, input int t0);
        chk({tag, "_count"}, 64'(mon_dout.size() - n0), 64'(eq_dout.size()));
        for (int j = 0; j < eq_dout.size(); j++) begin
            if (n0 + j < mon_dout.size()) begin
                chk($sformatf("%s_sel%0d", tag, j),  64'(mon_sel[n0+j]),       64'(eq_sel[j]));
                chk($sformatf("%s_dout%0d", tag, j), 64'(mon_dout[n0+j]),      64'(eq_dout[j]));
                chk($sformatf("%s_cyc%0d", tag, j),  64'(mon_cyc[n0+j] - t0),  64'(eq_cyc[j]));
            end
        end
        eq_dout.delete();
        eq_sel.delete();
        eq_cyc.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n0;
        int t0;
        int ca [10];

        // Reset state
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_vld",  64'(vld_if), 64'd0);
        chk("rst_ack",  64'(ack),    64'd0);
        chk("rst_dout", 64'(dout),   64'd0);
        chk("rst_sel",  64'(sel),    64'd0);

        // A: sole requester 2, bursts of 4 separated by one bubble
        do_reset();
        base[2] = 32'hA0; limit[2] = 10; en[2] = 1'b1;
        n0 = mon_dout.size(); t0 = cyc;
        ca = '{2, 3, 4, 5, 7, 8, 9, 10, 12, 13};
        for (int j = 0; j < 10; j++) add_exp(2'd2, 32'hA0 + 32'(j), ca[j]);
        @(negedge clk);
        chk("a_ack_c0", 64'(ack), 64'h0);
        next_cycle();
        @(negedge clk);
        chk("a_ack_c1", 64'(ack), 64'h4);
        repeat (15) next_cycle();
        compare_stream("a", n0, t0);

        // B: all four requesters valid, grant order 0,1,2,3,0
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            base[i]  = 32'h100 * 32'(i);
            limit[i] = (i == 0) ? 8 : 4;
        end
        en = 4'hF;
        n0 = mon_dout.size(); t0 = cyc;
        for (int b = 0; b < 5; b++) begin
            for (int w = 0; w < 4; w++) begin
                add_exp(2'(b % 4), 32'h100 * 32'(b % 4) + 32'((b == 4) ? 4 + w : w), 2 + 5*b + w);
            end
        end
        repeat (30) next_cycle();
        compare_stream("b", n0, t0);

        // C: downstream backpressure for 5 cycles mid-burst
        do_reset();
        base[1] = 32'hC0; limit[1] = 4; en[1] = 1'b1;
        n0 = mon_dout.size(); t0 = cyc;
        repeat (3) next_cycle();
        ack_if = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("c_hold_dout%0d", k), 64'(dout),   64'hC1);
            chk($sformatf("c_hold_sel%0d", k),  64'(sel),    64'd1);
            chk($sformatf("c_hold_vld%0d", k),  64'(vld_if), 64'd1);
            chk($sformatf("c_hold_ack%0d", k),  64'(ack),    64'h0);
            next_cycle();
        end
        ack_if = 1'b1;
        repeat (6) next_cycle();
        add_exp(2'd1, 32'hC0, 2);
        add_exp(2'd1, 32'hC1, 8);
        add_exp(2'd1, 32'hC2, 9);
        add_exp(2'd1, 32'hC3, 10);
        compare_stream("c", n0, t0);

        // D: requester 1 withdraws after 2 words, requester 3 pending
        do_reset();
        base[1] = 32'hD10; limit[1] = 2; en[1] = 1'b1;
        base[3] = 32'hD30; limit[3] = 4; en[3] = 1'b1;
        n0 = mon_dout.size(); t0 = cyc;
        repeat (4) next_cycle();
        @(negedge clk);
        chk("d_ptr", 64'(dut.r_ptr), 64'd2);
        chk("d_idle_ack", 64'(ack), 64'h0);
        repeat (8) next_cycle();
        add_exp(2'd1, 32'hD10, 2);
        add_exp(2'd1, 32'hD11, 3);
        for (int j = 0; j < 4; j++) add_exp(2'd3, 32'hD30 + 32'(j), 6 + j);
        compare_stream("d", n0, t0);

        // E: wrap-around from ptr=3 with requesters 0 and 3 valid
        do_reset();
        base[2] = 32'hE20; limit[2] = 1; en[2] = 1'b1;
        n0 = mon_dout.size(); t0 = cyc;
        repeat (3) next_cycle();
        base[0] = 32'hE00; limit[0] = 4; en[0] = 1'b1;
        base[3] = 32'hE30; limit[3] = 4; en[3] = 1'b1;
        @(negedge clk);
        chk("e_ptr", 64'(dut.r_ptr), 64'd3);
        repeat (12) next_cycle();
        add_exp(2'd2, 32'hE20, 2);
        for (int j = 0; j < 4; j++) add_exp(2'd3, 32'hE30 + 32'(j), 5 + j);
        for (int j = 0; j < 4; j++) add_exp(2'd0, 32'hE00 + 32'(j), 10 + j);
        compare_stream("e", n0, t0);

        // F: reset mid-burst with a word pending
        do_reset();
        base[2] = 32'hF20; limit[2] = 100; en[2] = 1'b1;
        repeat (3) next_cycle();
        reset = 1'b1;
        base[1] = 32'hF10; limit[1] = 100; en[1] = 1'b1;
        base[3] = 32'hF30; limit[3] = 100; en[3] = 1'b1;
        @(negedge clk);
        chk("f_pre_vld", 64'(vld_if), 64'd1);
        next_cycle();
        reset = 1'b0;
        n0 = mon_dout.size();
        @(negedge clk);
        chk("f_vld",   64'(vld_if),      64'd0);
        chk("f_dout",  64'(dout),        64'd0);
        chk("f_sel",   64'(sel),         64'd0);
        chk("f_ack",   64'(ack),         64'h0);
        chk("f_state", 64'(dut.r_state), 64'd0);
        repeat (4) next_cycle();
        chk("f_have_word", 64'(mon_dout.size() > n0), 64'd1);
        if (mon_dout.size() > n0) begin
            chk("f_first_sel",  64'(mon_sel[n0]),  64'd1);
            chk("f_first_dout", 64'(mon_dout[n0]), 64'hF10);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
